// File: rtl/stack_lifo_param.sv
// Parametrised LIFO stack with registered top-of-stack view, full/empty status,
// replace-top on push+pop, range-checked pointer jumps, sticky error flags and
// a high-water mark of stack occupancy.
module stack_lifo_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              jmp,
    input  logic [ADDR_W:0]   jump,
    input  logic [DATA_W-1:0] inn,
    input  logic              clr_err,
    output logic [DATA_W-1:0] peek,
    output logic [ADDR_W:0]   stack_pointer,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf,
    output logic              jerr,
    output logic [ADDR_W:0]   hwm
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO   = PTR_W'(2);

    // Storage array (not reset) plus a per-entry written bitmap (reset) that
    // masks never-written entries to zero so jumps cannot expose X.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;

    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [PTR_W-1:0]  hwm_q, hwm_d;
    logic [DATA_W-1:0] peek_q, peek_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              jerr_q, jerr_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic              ovf_set, unf_set, jerr_set;

    logic [ADDR_W-1:0] pop_idx, jmp_idx;
    logic [DATA_W-1:0] pop_data, jmp_data;

    // Read ports: new top after a pop (mem[sp-2]) and after a jump (mem[jump-1]).
    assign pop_idx  = ADDR_W'(sp_q - PTR_TWO);
    assign jmp_idx  = ADDR_W'(jump - PTR_ONE);
    assign pop_data = valid_q[pop_idx] ? mem_q[pop_idx] : '0;
    assign jmp_data = valid_q[jmp_idx] ? mem_q[jmp_idx] : '0;

    assign empty = (sp_q == '0);
    assign full  = (sp_q == DEPTH_PTR);

    // Operation decode by priority: push&pop > pop > push > jmp.
    always_comb begin
        sp_d     = sp_q;
        peek_d   = peek_q;
        valid_d  = valid_q;
        wr_en    = 1'b0;
        wr_idx   = '0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        jerr_set = 1'b0;

        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = ADDR_W'(sp_q - PTR_ONE);
            peek_d = inn;
        end else if (pop && !push) begin
            if (!empty) begin
                sp_d   = sp_q - PTR_ONE;
                peek_d = (sp_q == PTR_ONE) ? '0 : pop_data;
            end else begin
                unf_set = 1'b1;
            end
        end else if (push) begin
            // Also covers push&pop on an empty stack.
            if (!full) begin
                wr_en  = 1'b1;
                wr_idx = ADDR_W'(sp_q);
                sp_d   = sp_q + PTR_ONE;
                peek_d = inn;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (jmp) begin
            if (jump <= DEPTH_PTR) begin
                sp_d   = jump;
                peek_d = (jump == '0) ? '0 : jmp_data;
            end else begin
                jerr_set = 1'b1;
            end
        end

        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Sticky flags and high-water mark; a same-cycle error beats clr_err.
    always_comb begin
        ovf_d  = (ovf_q  & ~clr_err) | ovf_set;
        unf_d  = (unf_q  & ~clr_err) | unf_set;
        jerr_d = (jerr_q & ~clr_err) | jerr_set;
        hwm_d  = hwm_q;
        if (clr_err) begin
            hwm_d = sp_d;
        end else if (sp_d > hwm_q) begin
            hwm_d = sp_d;
        end
    end

    // Control and status registers, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= '0;
            peek_q  <= '0;
            hwm_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            jerr_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            sp_q    <= sp_d;
            peek_q  <= peek_d;
            hwm_q   <= hwm_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            jerr_q  <= jerr_d;
            valid_q <= valid_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= inn;
        end
    end

    assign peek          = peek_q;
    assign stack_pointer = sp_q;
    assign ovf           = ovf_q;
    assign unf           = unf_q;
    assign jerr          = jerr_q;
    assign hwm           = hwm_q;

endmodule

// File: tb/tb_stack_lifo_param.sv
// Scoreboard bench for stack_lifo_param (DATA_W=16, ADDR_W=2): directed
// scenarios followed by randomized traffic against an array-based model.
module tb_stack_lifo_param;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push = 1'b0, pop = 1'b0, jmp = 1'b0, clr_err = 1'b0;
    logic [ADDR_W:0]   jump = '0;
    logic [DATA_W-1:0] inn = '0;
    logic [DATA_W-1:0] peek;
    logic [ADDR_W:0]   stack_pointer, hwm;
    logic              empty, full, ovf, unf, jerr;

    stack_lifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .jmp(jmp), .jump(jump),
        .inn(inn), .clr_err(clr_err), .peek(peek), .stack_pointer(stack_pointer),
        .empty(empty), .full(full), .ovf(ovf), .unf(unf), .jerr(jerr), .hwm(hwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sp;
        int peek;
        int ovf;
        int unf;
        int jerr;
        int hwm;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: occupancy count over a plain array of entries.
    int m_sp, m_peek, m_hwm;
    int m_ovf, m_unf, m_jerr;
    int m_mem [DEPTH];
    bit m_written [DEPTH];

    function automatic int m_read(int idx);
        return m_written[idx] ? m_mem[idx] : 0;
    endfunction

    task automatic model_reset();
        m_sp = 0; m_peek = 0; m_hwm = 0;
        m_ovf = 0; m_unf = 0; m_jerr = 0;
        for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
    endtask

    task automatic model_step(bit pu, bit po, bit jm, int jt, int d, bit clr);
        int e_o, e_u, e_j;
        e_o = 0; e_u = 0; e_j = 0;
        if (pu && po && m_sp > 0) begin
            m_mem[m_sp-1] = d; m_written[m_sp-1] = 1'b1; m_peek = d;
        end else if (po && !pu) begin
            if (m_sp > 0) begin
                m_sp = m_sp - 1;
                m_peek = (m_sp == 0) ? 0 : m_read(m_sp - 1);
            end else e_u = 1;
        end else if (pu) begin
            if (m_sp < DEPTH) begin
                m_mem[m_sp] = d; m_written[m_sp] = 1'b1;
                m_sp = m_sp + 1; m_peek = d;
            end else e_o = 1;
        end else if (jm) begin
            if (jt <= DEPTH) begin
                m_sp = jt;
                m_peek = (jt == 0) ? 0 : m_read(jt - 1);
            end else e_j = 1;
        end
        m_ovf  = ((m_ovf  != 0) && !clr) || (e_o != 0) ? 1 : 0;
        m_unf  = ((m_unf  != 0) && !clr) || (e_u != 0) ? 1 : 0;
        m_jerr = ((m_jerr != 0) && !clr) || (e_j != 0) ? 1 : 0;
        if (clr) m_hwm = m_sp;
        else if (m_sp > m_hwm) m_hwm = m_sp;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one operation for one cycle and queue the expected result.
    task automatic do_op(bit pu, bit po, bit jm, int jt, int d, bit clr);
        exp_t e;
        @(negedge clk);
        push = pu; pop = po; jmp = jm; clr_err = clr;
        jump = (ADDR_W+1)'(jt); inn = DATA_W'(d);
        model_step(pu, po, jm, jt, d, clr);
        e.sp = m_sp; e.peek = m_peek; e.ovf = m_ovf; e.unf = m_unf;
        e.jerr = m_jerr; e.hwm = m_hwm;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        do_op(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Wait until the last queued op has taken effect.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; jmp = 1'b0; clr_err = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_sp", 32'(stack_pointer), 32'd0);
        check("rst_peek", 32'(peek), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_hwm", 32'(hwm), 32'd0);
        check("rst_flags", 32'({ovf, unf, jerr}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every cycle the DUT presents the result of the op queued before.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sp", 32'(stack_pointer), 32'(e.sp));
                check("peek", 32'(peek), 32'(e.peek));
                check("empty", 32'(empty), 32'(e.sp == 0));
                check("full", 32'(full), 32'(e.sp == DEPTH));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("unf", 32'(unf), 32'(e.unf));
                check("jerr", 32'(jerr), 32'(e.jerr));
                check("hwm", 32'(hwm), 32'(e.hwm));
            end
        end
    end

    initial begin
        int r;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-stream after three pushes.
        do_op(1, 0, 0, 0, 'h0101, 0);
        do_op(1, 0, 0, 0, 'h0202, 0);
        do_op(1, 0, 0, 0, 'h0303, 0);
        async_reset();

        // Fill, overflow, drain.
        do_op(1, 0, 0, 0, 'h1111, 0);
        do_op(1, 0, 0, 0, 'h2222, 0);
        do_op(1, 0, 0, 0, 'h3333, 0);
        do_op(1, 0, 0, 0, 'h4444, 0);
        settle();
        check("t2_full", 32'(full), 32'd1);
        check("t2_peek", 32'(peek), 32'h4444);
        do_op(1, 0, 0, 0, 'h5555, 0);
        settle();
        check("t2_ovf", 32'(ovf), 32'd1);
        check("t2_ovf_sp", 32'(stack_pointer), 32'd4);
        check("t2_ovf_peek", 32'(peek), 32'h4444);
        do_op(0, 1, 0, 0, 0, 0);
        do_op(0, 1, 0, 0, 0, 0);
        do_op(0, 1, 0, 0, 0, 0);
        settle();
        check("t2_pop3_peek", 32'(peek), 32'h1111);
        do_op(0, 1, 0, 0, 0, 0);
        settle();
        check("t2_drained", 32'({empty, peek}), 32'h1_0000);

        // Underflow then clear (clear also resets hwm to current occupancy).
        do_op(0, 1, 0, 0, 0, 0);
        settle();
        check("t3_unf", 32'(unf), 32'd1);
        do_op(0, 0, 0, 0, 0, 1);
        settle();
        check("t3_clr", 32'({unf, ovf, 3'(hwm)}), 32'd0);

        // Replace top.
        do_op(1, 0, 0, 0, 'hAAAA, 0);
        do_op(1, 0, 0, 0, 'hBBBB, 0);
        do_op(1, 1, 0, 0, 'hCCCC, 0);
        settle();
        check("t4_sp", 32'(stack_pointer), 32'd2);
        check("t4_peek", 32'(peek), 32'hCCCC);
        do_op(0, 1, 0, 0, 0, 0);
        settle();
        check("t4_pop", 32'(peek), 32'hAAAA);

        // Jumps: legal, out of range, to zero.
        do_op(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) do_op(1, 0, 0, 0, 'h7000 + i, 0);
        do_op(0, 0, 1, 2, 0, 0);
        settle();
        check("t5_jmp_sp", 32'(stack_pointer), 32'd2);
        check("t5_jmp_peek", 32'(peek), 32'h7001);
        do_op(0, 0, 1, 5, 0, 0);
        settle();
        check("t5_jerr", 32'({jerr, 3'(stack_pointer)}), 32'b1010);
        do_op(0, 0, 1, 0, 0, 0);
        settle();
        check("t5_jmp0", 32'({empty, peek}), 32'h1_0000);
        check("t5_hwm", 32'(hwm), 32'd4);
        do_op(0, 0, 1, 3, 0, 0);
        settle();
        check("t5_jmp_up", 32'(peek), 32'h7002);
        do_op(0, 0, 1, 0, 0, 1);

        // push&pop on empty acts as push, no underflow.
        do_op(1, 1, 0, 0, 'h0F0F, 0);
        settle();
        check("t6_sp", 32'(stack_pointer), 32'd1);
        check("t6_peek", 32'(peek), 32'h0F0F);
        check("t6_unf", 32'(unf), 32'd0);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            if (i == 250 || i == 480) async_reset();
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: do_op(1, 0, 0, 0, int'($urandom_range(0, 16'hFFFF)), $urandom_range(0, 15) == 0);
                3, 4, 5: do_op(0, 1, 0, 0, 0, $urandom_range(0, 15) == 0);
                6:       do_op(1, 1, 0, 0, int'($urandom_range(0, 16'hFFFF)), 1'b0);
                7, 8:    do_op(0, 0, 1, int'($urandom_range(0, 7)), 0, $urandom_range(0, 7) == 0);
                default: do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                               int'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)));
            endcase
        end

        idle();
        idle();
        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
